// File: rtl/dense_backprop_calculator_pkg.sv
// Shared definitions for the dense backprop stage: FSM encoding and
// fixed-point helpers (fraction bits, saturation bounds).
package dense_backprop_calculator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of fraction bits for a Q(n/2).(n/2) value of width data_size
    function automatic int frac_bits(input int data_size);
        return data_size / 2;
    endfunction

    // Largest representable signed value of width data_size
    function automatic longint sat_max(input int data_size);
        return (longint'(1) <<< (data_size - 1)) - 1;
    endfunction

    // Smallest representable signed value of width data_size
    function automatic longint sat_min(input int data_size);
        return -(longint'(1) <<< (data_size - 1));
    endfunction

endpackage

// File: rtl/dense_backprop_calculator_mac.sv
// Combinational fixed-point MAC: full-width product added to a wide
// accumulator, plus the shifted and saturated element value that the
// accumulator-plus-product would produce if this were the last term.
module fixed_mac_sat
    import dense_backprop_calculator_pkg::*;
#(
    parameter int data_size = 16,
    parameter int acc_width = 35
) (
    input  logic signed [data_size-1:0] a,
    input  logic signed [data_size-1:0] b,
    input  logic signed [acc_width-1:0] acc_in,
    output logic signed [acc_width-1:0] acc_next,
    output logic signed [data_size-1:0] result
);

    localparam int FRAC_BITS = frac_bits(data_size);
    localparam logic signed [acc_width-1:0] MAX_VAL = acc_width'(sat_max(data_size));
    localparam logic signed [acc_width-1:0] MIN_VAL = acc_width'(sat_min(data_size));

    logic signed [2*data_size-1:0] product;
    logic signed [acc_width-1:0]   shifted;

    // Multiply, accumulate unshifted, then floor-shift and clamp the total
    always_comb begin
        product  = a * b;
        acc_next = acc_in + acc_width'(product);
        shifted  = acc_next >>> FRAC_BITS;
        if (shifted > MAX_VAL) begin
            result = MAX_VAL[data_size-1:0];
        end else if (shifted < MIN_VAL) begin
            result = MIN_VAL[data_size-1:0];
        end else begin
            result = shifted[data_size-1:0];
        end
    end

endmodule

// File: rtl/dense_backprop_calculator.sv
// Computes dC/da of the previous layer: diff_dense[j] = sum_i W[i][j]*dz[i],
// using one time-multiplexed MAC (i inner, j outer). The result vector is
// published atomically when the run finishes.
module dense_backprop_calculator
    import dense_backprop_calculator_pkg::*;
#(
    parameter int data_size = 16,
    parameter int size      = 3,
    parameter int prev_size = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [data_size*size-1:0]             diff_z_to_z,
    input  logic [data_size*size*prev_size-1:0]   weights,
    output logic [data_size*prev_size-1:0]        diff_dense,
    output logic                                  busy,
    output logic                                  done
);

    localparam int ACC_W = 2*data_size + $clog2(size) + 1;
    localparam int I_W   = (size > 1) ? $clog2(size) : 1;
    localparam int J_W   = (prev_size > 1) ? $clog2(prev_size) : 1;
    localparam logic [I_W-1:0] I_LAST = I_W'(size - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(prev_size - 1);

    state_t state, next_state;
    logic   load;

    logic [I_W-1:0]             i_cnt;
    logic [J_W-1:0]             j_cnt;
    logic signed [ACC_W-1:0]    acc, acc_next;
    logic signed [data_size-1:0] op_z [size];
    logic signed [data_size-1:0] op_w [size][prev_size];
    logic signed [data_size-1:0] shadow [prev_size];
    logic signed [data_size-1:0] dense_reg [prev_size];
    logic signed [data_size-1:0] cur_z, cur_w, mac_result;

    // Select the operand pair for the current (i, j) step
    always_comb begin
        cur_z = op_z[i_cnt];
        cur_w = op_w[i_cnt][j_cnt];
    end

    fixed_mac_sat #(
        .data_size (data_size),
        .acc_width (ACC_W)
    ) u_mac (
        .a        (cur_w),
        .b        (cur_z),
        .acc_in   (acc),
        .acc_next (acc_next),
        .result   (mac_result)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and status outputs; a start in DONE chains straight into a new run
    always_comb begin
        next_state = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (i_cnt == I_LAST && j_cnt == J_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = MAC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, counters, accumulator, shadow results and published output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_cnt <= '0;
            j_cnt <= '0;
            acc   <= '0;
            for (int ii = 0; ii < size; ii++) begin
                op_z[ii] <= '0;
                for (int jj = 0; jj < prev_size; jj++) begin
                    op_w[ii][jj] <= '0;
                end
            end
            for (int jj = 0; jj < prev_size; jj++) begin
                shadow[jj]    <= '0;
                dense_reg[jj] <= '0;
            end
        end else if (load) begin
            i_cnt <= '0;
            j_cnt <= '0;
            acc   <= '0;
            for (int ii = 0; ii < size; ii++) begin
                op_z[ii] <= diff_z_to_z[data_size*(size-ii)-1 -: data_size];
                for (int jj = 0; jj < prev_size; jj++) begin
                    op_w[ii][jj] <= weights[data_size*(size*prev_size-(ii*prev_size+jj))-1 -: data_size];
                end
            end
        end else if (state == MAC) begin
            if (i_cnt == I_LAST) begin
                shadow[j_cnt] <= mac_result;
                acc           <= '0;
                i_cnt         <= '0;
                if (j_cnt == J_LAST) begin
                    j_cnt <= '0;
                    for (int jj = 0; jj < prev_size; jj++) begin
                        dense_reg[jj] <= (jj == int'(j_cnt)) ? mac_result : shadow[jj];
                    end
                end else begin
                    j_cnt <= j_cnt + 1'b1;
                end
            end else begin
                acc   <= acc_next;
                i_cnt <= i_cnt + 1'b1;
            end
        end
    end

    // Pack the published vector, element 0 in the most significant slot
    always_comb begin
        diff_dense = '0;
        for (int jj = 0; jj < prev_size; jj++) begin
            diff_dense[data_size*(prev_size-jj)-1 -: data_size] = dense_reg[jj];
        end
    end

endmodule

// File: tb/tb_dense_backprop_calculator.sv
// Self-checking bench for dense_backprop_calculator at default parameters.
module tb_dense_backprop_calculator;

    localparam int DS = 16;
    localparam int SZ = 3;
    localparam int PS = 3;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [DS*SZ-1:0]       diff_z_to_z;
    logic [DS*SZ*PS-1:0]    weights;
    logic [DS*PS-1:0]       diff_dense;
    logic                   busy;
    logic                   done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int done_count   = 0;

    int               acc_edge_q [$];
    logic [DS*PS-1:0] acc_res_q  [$];

    dense_backprop_calculator #(
        .data_size (DS),
        .size      (SZ),
        .prev_size (PS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .diff_z_to_z (diff_z_to_z),
        .weights     (weights),
        .diff_dense  (diff_dense),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value after edge n is n
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: dC/da_prev[j] = floor(sum_i W[i][j]*dz[i] / 256), clamped to int16
    function automatic logic [DS*PS-1:0] model_dense(input logic [DS*SZ-1:0] z, input logic [DS*SZ*PS-1:0] w);
        logic [DS*PS-1:0] res;
        logic [DS-1:0]    zv, wv;
        longint           s;
        res = '0;
        for (int j = 0; j < PS; j++) begin
            s = 0;
            for (int i = 0; i < SZ; i++) begin
                zv = z[DS*(SZ-i)-1 -: DS];
                wv = w[DS*(SZ*PS-(i*PS+j))-1 -: DS];
                s += longint'($signed(zv)) * longint'($signed(wv));
            end
            s = s >>> (DS/2);
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            res[DS*(PS-j)-1 -: DS] = DS'(s);
        end
        return res;
    endfunction

    function automatic logic [DS*SZ*PS-1:0] identity_w();
        logic [DS*SZ*PS-1:0] w;
        w = '0;
        for (int i = 0; i < SZ; i++) begin
            w[DS*(SZ*PS-(i*PS+i))-1 -: DS] = 16'h0100;
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    // Drive one start pulse; the bench decides independently whether the run is accepted
    task automatic applyStimulus(input logic [DS*SZ-1:0] z, input logic [DS*SZ*PS-1:0] w, output int edge_n);
        @(negedge clk);
        diff_z_to_z = z;
        weights     = w;
        start       = 1'b1;
        edge_n      = cyc + 1;
        if (acc_edge_q.size() == 0 || edge_n >= acc_edge_q[$] + 10) begin
            acc_edge_q.push_back(edge_n);
            acc_res_q.push_back(model_dense(z, w));
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int at_cyc);
        bit found;
        found  = 1'b0;
        at_cyc = -1;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (done) begin
                found  = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!found) checkOutput({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Every cycle: compare done/busy/diff_dense with the schedule of accepted runs
    always @(negedge clk) begin
        logic [DS*PS-1:0] exp_dense;
        logic             exp_busy, exp_done;
        exp_dense = '0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        if (!rst) begin
            for (int n = 0; n < acc_edge_q.size(); n++) begin
                if (cyc >= acc_edge_q[n] && cyc <= acc_edge_q[n] + 9) exp_busy = 1'b1;
                if (cyc == acc_edge_q[n] + 9) exp_done = 1'b1;
                if (cyc >= acc_edge_q[n] + 9) exp_dense = acc_res_q[n];
            end
        end
        if (done) done_count++;
        checkOutput("cyc_done", 64'(done), 64'(exp_done));
        checkOutput("cyc_busy", 64'(busy), 64'(exp_busy));
        checkOutput("cyc_dense", 64'(diff_dense), 64'(exp_dense));
    end

    initial begin
        int e, e2, e3, at, dc0;
        logic [DS*SZ-1:0]    z1;
        logic [DS*SZ*PS-1:0] w1;
        z1          = {16'h0100, 16'h0200, 16'hFF00};
        w1          = identity_w();
        rst         = 1'b1;
        start       = 1'b0;
        diff_z_to_z = '0;
        weights     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_dense", 64'(diff_dense), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Identity weights pass the vector straight through
        applyStimulus(z1, w1, e);
        wait_done("t1", at);
        checkOutput("t1_latency", 64'(at - e), 64'd9);
        checkOutput("t1_dense", 64'(diff_dense), 64'h0100_0200_FF00);

        // Half weights; inputs scrambled after the start edge
        applyStimulus({3{16'h0100}}, {9{16'h0080}}, e);
        diff_z_to_z = {3{16'h7777}};
        weights     = {9{16'h1234}};
        wait_done("t2", at);
        checkOutput("t2_dense", 64'(diff_dense), 64'h0180_0180_0180);

        // Sum before shift, and floor on negatives
        applyStimulus({3{16'h0080}}, {9{16'h0001}}, e);
        wait_done("t3a", at);
        checkOutput("t3a_dense", 64'(diff_dense), 64'h0001_0001_0001);
        applyStimulus({3{16'h0080}}, {9{16'hFFFF}}, e);
        wait_done("t3b", at);
        checkOutput("t3b_dense", 64'(diff_dense), 64'hFFFE_FFFE_FFFE);

        // Saturation in both directions
        applyStimulus({3{16'h6400}}, {9{16'h6400}}, e);
        wait_done("t4a", at);
        checkOutput("t4a_dense", 64'(diff_dense), 64'h7FFF_7FFF_7FFF);
        applyStimulus({3{16'h9C00}}, {9{16'h6400}}, e);
        wait_done("t4b", at);
        checkOutput("t4b_dense", 64'(diff_dense), 64'h8000_8000_8000);

        // Asynchronous abort in the middle of a run
        applyStimulus(z1, w1, e);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        acc_edge_q.delete();
        acc_res_q.delete();
        #1;
        checkOutput("t5_rst_dense", 64'(diff_dense), 64'd0);
        checkOutput("t5_rst_busy", 64'(busy), 64'd0);
        checkOutput("t5_rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        dc0 = done_count;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t5_no_done", 64'(done_count - dc0), 64'd0);
        applyStimulus(z1, w1, e);
        wait_done("t5", at);
        checkOutput("t5_dense", 64'(diff_dense), 64'h0100_0200_FF00);

        // Start ignored mid-run, accepted during DONE
        repeat (2) @(posedge clk);
        #1 dc0 = done_count;
        applyStimulus({3{16'h0080}}, {9{16'h0001}}, e);
        repeat (4) @(posedge clk);
        applyStimulus({3{16'h0100}}, {9{16'h0100}}, e2);
        repeat (4) @(posedge clk);
        applyStimulus({3{16'h0100}}, {9{16'h0080}}, e3);
        checkOutput("t6_edges", 64'(e3 - e), 64'd10);
        wait_done("t6", at);
        checkOutput("t6_gap", 64'(at - e), 64'd19);
        checkOutput("t6_dense", 64'(diff_dense), 64'h0180_0180_0180);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t6_done_pulses", 64'(done_count - dc0), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
